// File: rtl/mc_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer (master) and the memories (slave).
interface mc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS16 core with handshake timeout.
// Define MC_SEQ_PERF_EN to add the cycle_cnt / instr_cnt performance counters.
//
//  state  | meaning
//  FETCH  | imem_req high; on imem_ready load IR and PC+2
//  DECODE | capture opcode and JR flag
//  EXEC   | jumps/branches retire here, others go to MEM or WB
//  MEM    | dmem_req high until dmem_ready; SW retires here
//  WB     | register file write, retire
//  ERR    | handshake timeout, all enables off until rst
module mc_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_sequencer_if.master       bus,
    input  logic [2:0]           opcode,
    input  logic                 is_jr,
    input  logic                 alu_zero,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 rf_we,
    output logic                 instr_done,
    output logic                 bus_err,
    output logic [2:0]           state
`ifdef MC_SEQ_PERF_EN
    ,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          instr_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd7
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    state_t            state_q;
    logic [2:0]        op_q;
    logic              jr_q;
    logic [WAIT_W-1:0] wait_cnt;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            op_q     <= '0;
            jr_q     <= 1'b0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            // Counter only survives while a request stays pending; any other cycle clears it.
            wait_cnt <= '0;
            case (state_q)
                FETCH: begin
                    if (bus.imem_ready) begin
                        state_q <= DECODE;
                    end else if (wait_cnt == MAX_CNT) begin
                        bus_err <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                DECODE: begin
                    op_q    <= opcode;
                    jr_q    <= is_jr & (opcode == OP_R);
                    state_q <= EXEC;
                end
                EXEC: begin
                    case (op_q)
                        OP_R:             state_q <= jr_q ? FETCH : WB;
                        OP_SLTI, OP_ADDI: state_q <= WB;
                        OP_LW, OP_SW:     state_q <= MEM;
                        default:          state_q <= FETCH;
                    endcase
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        state_q <= (op_q == OP_SW) ? FETCH : WB;
                    end else if (wait_cnt == MAX_CNT) begin
                        bus_err <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                WB:      state_q <= FETCH;
                ERR:     state_q <= ERR;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Enables depend on same-cycle ready/zero so accept and retire cost no extra cycle.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        rf_we        = 1'b0;
        instr_done   = 1'b0;
        case (state_q)
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        if (jr_q) begin
                            pc_we      = 1'b1;
                            pc_src     = 2'd3;
                            instr_done = 1'b1;
                        end
                    end
                    OP_J: begin
                        pc_we      = 1'b1;
                        pc_src     = 2'd2;
                        instr_done = 1'b1;
                    end
                    OP_JAL: begin
                        pc_we      = 1'b1;
                        pc_src     = 2'd2;
                        rf_we      = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_BEQ: begin
                        pc_we      = alu_zero;
                        pc_src     = 2'd1;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (op_q == OP_SW);
                if (bus.dmem_ready && (op_q == OP_SW)) begin
                    instr_done = 1'b1;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef MC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_done) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle state and enable vectors against hand-computed values.
module tb_mc_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       is_jr;
    logic       alu_zero;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       rf_we;
    logic       instr_done;
    logic       bus_err;
    logic [2:0] state;
`ifdef MC_SEQ_PERF_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    mc_sequencer_if bus ();

    mc_sequencer #(.MAX_WAIT(15), .WAIT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .opcode     (opcode),
        .is_jr      (is_jr),
        .alu_zero   (alu_zero),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .rf_we      (rf_we),
        .instr_done (instr_done),
        .bus_err    (bus_err),
        .state      (state)
`ifdef MC_SEQ_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {imem_req, ir_we, pc_we, pc_src[1:0], dmem_req, dmem_we, rf_we, instr_done}
    logic [8:0] flags;
    assign flags = {bus.imem_req, ir_we, pc_we, pc_src, bus.dmem_req, bus.dmem_we, rf_we, instr_done};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered #1 after a rising edge with inputs already set; leaves #1 after the next edge.
    task automatic step(input string tag, input logic [2:0] st, input logic [8:0] fl);
        #1;
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".flags"}, 32'(flags), 32'(fl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    localparam logic [8:0] F_ACC  = 9'b1_1_1_00_0_0_0_0;
    localparam logic [8:0] F_REQ  = 9'b1_0_0_00_0_0_0_0;
    localparam logic [8:0] F_NONE = 9'b0_0_0_00_0_0_0_0;
    localparam logic [8:0] F_WB   = 9'b0_0_0_00_0_0_1_1;
    localparam logic [8:0] F_LW   = 9'b0_0_0_00_1_0_0_0;
    localparam logic [8:0] F_SW   = 9'b0_0_0_00_1_1_0_0;
    localparam logic [8:0] F_SWD  = 9'b0_0_0_00_1_1_0_1;

    initial begin
        rst             = 1'b1;
        opcode          = 3'b000;
        is_jr           = 1'b0;
        alu_zero        = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.dmem_ready  = 1'b0;
        do_reset();

        #1;
        check("reset.state", 32'(state), 32'd0);
        check("reset.flags", 32'(flags), 32'(F_REQ));
        check("reset.bus_err", 32'(bus_err), 32'd0);
        #1;
        @(posedge clk);
        #1;

        // ADDI, zero-wait memory
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        opcode = 3'b111;
        step("addi.fetch", 3'd0, F_ACC);
        step("addi.decode", 3'd1, F_NONE);
        step("addi.exec", 3'd2, F_NONE);
        step("addi.wb", 3'd4, F_WB);

        // LW with three wait cycles in MEM
        opcode = 3'b100;
        bus.dmem_ready = 1'b0;
        step("lw.fetch", 3'd0, F_ACC);
        step("lw.decode", 3'd1, F_NONE);
        step("lw.exec", 3'd2, F_NONE);
        for (int i = 0; i < 3; i++) step("lw.memwait", 3'd3, F_LW);
        bus.dmem_ready = 1'b1;
        step("lw.memrdy", 3'd3, F_LW);
        bus.dmem_ready = 1'b0;
        step("lw.wb", 3'd4, F_WB);

        // SW with immediate ready retires out of MEM
        opcode = 3'b101;
        bus.dmem_ready = 1'b1;
        step("sw.fetch", 3'd0, F_ACC);
        step("sw.decode", 3'd1, F_NONE);
        step("sw.exec", 3'd2, F_NONE);
        step("sw.mem", 3'd3, F_SWD);
        bus.dmem_ready = 1'b0;

        // BEQ taken then not taken
        opcode = 3'b110;
        alu_zero = 1'b1;
        step("beq1.fetch", 3'd0, F_ACC);
        step("beq1.decode", 3'd1, F_NONE);
        step("beq1.exec", 3'd2, 9'b0_0_1_01_0_0_0_1);
        alu_zero = 1'b0;
        step("beq0.fetch", 3'd0, F_ACC);
        step("beq0.decode", 3'd1, F_NONE);
        step("beq0.exec", 3'd2, 9'b0_0_0_01_0_0_0_1);

        // JAL links and jumps in one cycle
        opcode = 3'b011;
        step("jal.fetch", 3'd0, F_ACC);
        step("jal.decode", 3'd1, F_NONE);
        step("jal.exec", 3'd2, 9'b0_0_1_10_0_0_1_1);

        // JR: R-type with is_jr
        opcode = 3'b000;
        is_jr = 1'b1;
        step("jr.fetch", 3'd0, F_ACC);
        step("jr.decode", 3'd1, F_NONE);
        step("jr.exec", 3'd2, 9'b0_0_1_11_0_0_0_1);

        // is_jr ignored for non-R opcode: J stays a plain jump
        opcode = 3'b010;
        step("j.fetch", 3'd0, F_ACC);
        step("j.decode", 3'd1, F_NONE);
        step("j.exec", 3'd2, 9'b0_0_1_10_0_0_0_1);

        // R-type without JR goes through WB
        opcode = 3'b000;
        is_jr = 1'b0;
        step("r.fetch", 3'd0, F_ACC);
        step("r.decode", 3'd1, F_NONE);
        step("r.exec", 3'd2, F_NONE);
        step("r.wb", 3'd4, F_WB);

        // ready on the last allowed wait cycle is still accepted
        bus.imem_ready = 1'b0;
        opcode = 3'b010;
        for (int i = 0; i < 15; i++) step("edge.wait", 3'd0, F_REQ);
        bus.imem_ready = 1'b1;
        step("edge.accept", 3'd0, F_ACC);
        step("edge.decode", 3'd1, F_NONE);
        step("edge.exec", 3'd2, 9'b0_0_1_10_0_0_0_1);

        // fetch timeout
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) step("tmo.wait", 3'd0, F_REQ);
        #1;
        check("tmo.bus_err", 32'(bus_err), 32'd1);
        #1;
        bus.imem_ready = 1'b1;
        step("err.hold", 3'd7, F_NONE);
        step("err.hold2", 3'd7, F_NONE);
        #1;
        check("err.sticky", 32'(bus_err), 32'd1);
        #1;
        bus.imem_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("errrst.bus_err", 32'(bus_err), 32'd0);
        #1;
        step("errrst.fetch", 3'd0, F_REQ);

        // reset while SW waits in MEM aborts the access
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        opcode = 3'b101;
        step("swr.fetch", 3'd0, F_ACC);
        step("swr.decode", 3'd1, F_NONE);
        step("swr.exec", 3'd2, F_NONE);
        step("swr.mem", 3'd3, F_SW);
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("swr.after", 3'd0, F_REQ);

`ifdef MC_SEQ_PERF_EN
        opcode = 3'b111;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("perf.rst_cycle", cycle_cnt, 32'd0);
        for (int i = 0; i < 40; i++) @(posedge clk);
        #1;
        check("perf.instr_cnt", instr_cnt, 32'd10);
        check("perf.cycle_cnt", cycle_cnt, 32'd40);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
